// File: rtl/alu_issue.sv
// ============================================================================
// Module     : alu_issue
// Description: RV32 ALU issue stage: decodes add/sub/logic/shift instructions
//              into an ALU operand bus behind a 2-entry skid buffer.
//              Optional macro ALU_ISSUE_FWD_EN adds a result-forwarding port.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic [31:0] imm,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   input  logic [4:0]  rd,
   input  logic        flush,
   output logic [31:0] alu_op1,
   output logic [31:0] alu_op2,
   output logic [3:0]  alu_operand,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_rd,
   output logic        out_illegal
`ifdef ALU_ISSUE_FWD_EN
   ,
   input  logic        fwd_valid,
   input  logic [4:0]  fwd_rd,
   input  logic [31:0] fwd_data
`endif
);

   localparam logic [6:0] c_opc_r   = 7'b0110011;
   localparam logic [6:0] c_opc_i   = 7'b0010011;
   localparam logic [3:0] c_op_add  = 4'd0;
   localparam logic [3:0] c_op_sub  = 4'd1;
   localparam logic [3:0] c_op_and  = 4'd2;
   localparam logic [3:0] c_op_or   = 4'd3;
   localparam logic [3:0] c_op_xor  = 4'd4;
   localparam logic [3:0] c_op_sll  = 4'd5;
   localparam logic [3:0] c_op_srl  = 4'd6;

   logic [31:0] w_rs1;
   logic [31:0] w_rs2;

`ifdef ALU_ISSUE_FWD_EN
   // x0 is never a forwarding target, so fwd_rd==0 always falls back to the register file
   assign w_rs1 = (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == rs1_addr)) ? fwd_data : rs1_data;
   assign w_rs2 = (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == rs2_addr)) ? fwd_data : rs2_data;
`else
   logic w_unused_addr;
   assign w_unused_addr = ^{rs1_addr, rs2_addr};
   assign w_rs1 = rs1_data;
   assign w_rs2 = rs2_data;
`endif

   logic [3:0]  w_operand;
   logic [31:0] w_op1;
   logic [31:0] w_op2;
   logic [31:0] w_op2_sel;
   logic        w_illegal;
   logic        w_shift;

   always_comb begin
      w_operand = c_op_add;
      w_illegal = 1'b1;
      w_shift   = 1'b0;
      w_op2_sel = (opcode == c_opc_r) ? w_rs2 : imm;
      w_op1     = 32'd0;
      w_op2     = 32'd0;
      if ((opcode == c_opc_r) || (opcode == c_opc_i)) begin
         w_illegal = 1'b0;
         case (funct3)
            3'b000: w_operand = ((opcode == c_opc_r) && funct7b5) ? c_op_sub : c_op_add;
            3'b111: w_operand = c_op_and;
            3'b110: w_operand = c_op_or;
            3'b100: w_operand = c_op_xor;
            3'b001: begin
               w_operand = c_op_sll;
               w_shift   = 1'b1;
            end
            3'b101: begin
               // funct7b5=1 here is sra/srai, which this ALU does not implement
               if (!funct7b5) begin
                  w_operand = c_op_srl;
                  w_shift   = 1'b1;
               end else begin
                  w_illegal = 1'b1;
               end
            end
            default: w_illegal = 1'b1;
         endcase
      end
      if (w_illegal) begin
         w_operand = c_op_add;
      end else begin
         w_op1 = w_rs1;
         w_op2 = w_shift ? {27'd0, w_op2_sel[4:0]} : w_op2_sel;
      end
   end

   logic        r_out_valid;
   logic [31:0] r_op1;
   logic [31:0] r_op2;
   logic [3:0]  r_operand;
   logic [4:0]  r_rd;
   logic        r_illegal;
   logic        r_sk_valid;
   logic [31:0] r_sk_op1;
   logic [31:0] r_sk_op2;
   logic [3:0]  r_sk_operand;
   logic [4:0]  r_sk_rd;
   logic        r_sk_illegal;
   logic        r_in_ready;

   logic w_accept;
   logic w_out_free;
   logic w_sk_next;

   assign w_accept   = in_valid && r_in_ready;
   assign w_out_free = !r_out_valid || out_ready;
   // Skid fills only when the output is stalled; it drains into the output on any free edge
   assign w_sk_next  = flush ? 1'b0 :
                       r_sk_valid ? !w_out_free :
                       (w_accept && !w_out_free);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_op1        <= 32'd0;
         r_op2        <= 32'd0;
         r_operand    <= 4'd0;
         r_rd         <= 5'd0;
         r_illegal    <= 1'b0;
         r_sk_valid   <= 1'b0;
         r_sk_op1     <= 32'd0;
         r_sk_op2     <= 32'd0;
         r_sk_operand <= 4'd0;
         r_sk_rd      <= 5'd0;
         r_sk_illegal <= 1'b0;
         r_in_ready   <= 1'b1;
      end else begin
         r_sk_valid <= w_sk_next;
         r_in_ready <= !w_sk_next;
         if (flush) begin
            r_out_valid <= 1'b0;
         end else if (w_out_free) begin
            if (r_sk_valid) begin
               r_out_valid <= 1'b1;
               r_op1       <= r_sk_op1;
               r_op2       <= r_sk_op2;
               r_operand   <= r_sk_operand;
               r_rd        <= r_sk_rd;
               r_illegal   <= r_sk_illegal;
            end else if (w_accept) begin
               r_out_valid <= 1'b1;
               r_op1       <= w_op1;
               r_op2       <= w_op2;
               r_operand   <= w_operand;
               r_rd        <= rd;
               r_illegal   <= w_illegal;
            end else begin
               r_out_valid <= 1'b0;
            end
         end else if (w_accept) begin
            r_sk_op1     <= w_op1;
            r_sk_op2     <= w_op2;
            r_sk_operand <= w_operand;
            r_sk_rd      <= rd;
            r_sk_illegal <= w_illegal;
         end
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign alu_op1     = r_op1;
   assign alu_op2     = r_op2;
   assign alu_operand = r_operand;
   assign out_rd      = r_rd;
   assign out_illegal = r_illegal;

endmodule

`default_nettype wire
